// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up in a final cycle, results held in HI/LO with Start/Busy/Done handshake.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHI,
  input  logic             WrLO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_sa;
  logic                 r_sb;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_a_orig;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_divzero;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH+1:0]     w_trial;
  logic                 w_borrow;
  logic [2*WIDTH-1:0]   w_div_nxt;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;
  logic                 w_fix_dz;

  // Signed ops iterate on magnitudes; the sign flags are only set for signed ops.
  assign w_neg_a = Op[0] & A[WIDTH-1];
  assign w_neg_b = Op[0] & B[WIDTH-1];
  assign w_a_mag = w_neg_a ? neg_w(A) : A;
  assign w_b_mag = w_neg_b ? neg_w(B) : B;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // One multiply or divide iteration on the shared accumulator.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    if (r_acc[0]) begin
      w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_mul_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
    end
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_trial  = {1'b0, w_rem_sh} - {2'b00, r_opb};
    // A kept difference is always below the divisor, so bit WIDTH set also means borrow.
    w_borrow = |w_trial[WIDTH+1:WIDTH];
    if (w_borrow) begin
      w_div_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    w_prod   = (r_sa ^ r_sb) ? neg_2w(r_acc) : r_acc;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    w_fix_dz = 1'b0;
    if (r_is_div) begin
      if (r_opb == {WIDTH{1'b0}}) begin
        w_fix_hi = r_a_orig;
        w_fix_lo = {WIDTH{1'b1}};
        w_fix_dz = 1'b1;
      end else begin
        w_fix_hi = r_sa ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = (r_sa ^ r_sb) ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      end
    end else begin
      w_fix_dz = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_opb     <= '0;
      r_a_orig  <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt    <= '0;
            r_is_div <= Op[1];
            r_sa     <= w_neg_a;
            r_sb     <= w_neg_b;
            r_a_orig <= A;
            r_opb    <= Op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (Op[1] ? w_a_mag : w_b_mag)};
            r_busy   <= 1'b1;
          end else begin
            if (WrHI) r_hi <= A;
            if (WrLO) r_lo <= A;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_hi      <= w_fix_hi;
          r_lo      <= w_fix_lo;
          r_divzero <= w_fix_dz;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_divzero;
  assign HI      = r_hi;
  assign LO      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// reference model, and hand sequences for handshake/reset/MTHI/MTLO corners.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          WrHI;
  logic          WrLO;
  logic          Busy;
  logic          Done;
  logic          DivZero;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .WrHI(WrHI), .WrLO(WrLO), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sbv;
    e.dz = 1'b0;
    e.hi = 32'd0;
    e.lo = 32'd0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin e.lo = 32'(sa / sbv); e.hi = 32'(sa % sbv); end
      end
    endcase
    return e;
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    sb_q.push_back(e);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic compare_pop(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, " unexpected Done"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, " HI"}, {32'd0, HI}, {32'd0, e.hi});
      check({name, " LO"}, {32'd0, LO}, {32'd0, e.lo});
      check({name, " DivZero"}, {63'd0, DivZero}, {63'd0, e.dz});
    end
  endtask

  task automatic wait_done(input string name, input int skip, output int lat, output int bc);
    bit got;
    got = 1'b0;
    lat = skip;
    bc  = (skip == 0) ? int'(Busy) : 0;
    while (!got && lat < 45) begin
      @(posedge clk); #1;
      lat++;
      if (Busy) bc++;
      if (Done) got = 1'b1;
    end
    if (got) compare_pop(name);
    else check({name, " Done timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   bc;
    int   ndone;
    exp_t e;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[9] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0; WrHI = 1'b0; WrLO = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset HI", {32'd0, HI}, 64'd0);
    check("reset LO", {32'd0, LO}, 64'd0);
    check("reset Busy", {63'd0, Busy}, 64'd0);
    check("reset Done", {63'd0, Done}, 64'd0);
    check("reset DivZero", {63'd0, DivZero}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors; each start lands in the previous Done cycle (back-to-back).
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].hi, vecs[i].lo, vecs[i].dz});
      wait_done($sformatf("vec%0d", i), 0, lat, bc);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'd33);
    end
    @(posedge clk); #1;
    check("Done one-cycle pulse", {63'd0, Done}, 64'd0);
    check("Busy low after Done", {63'd0, Busy}, 64'd0);

    // Random ops checked against the reference model.
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      start_op(rop, ra, rb, model(rop, ra, rb));
      wait_done($sformatf("rand%0d op%0d", i, rop), 0, lat, bc);
      check($sformatf("rand%0d latency", i), 64'(lat), 64'd33);
    end

    // Start pulsed mid-operation must be ignored.
    start_op(2'b00, 32'd3, 32'd5, model(2'b00, 32'd3, 32'd5));
    ndone = 0;
    lat   = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c == 10) begin Start = 1'b1; Op = 2'b00; A = 32'd9; B = 32'd9; end
      if (c == 11) Start = 1'b0;
      if (Done) begin
        ndone++;
        if (ndone == 1) begin lat = c; compare_pop("start-ignored"); end
      end
    end
    check("start-ignored Done count", 64'(ndone), 64'd1);
    check("start-ignored latency", 64'(lat), 64'd33);

    // Reset during cycle 15 of a MULT aborts it.
    start_op(2'b01, 32'hFFFF_FFFD, 32'd7, model(2'b01, 32'hFFFF_FFFD, 32'd7));
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("abort Busy", {63'd0, Busy}, 64'd0);
    check("abort HI", {32'd0, HI}, 64'd0);
    check("abort LO", {32'd0, LO}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) ndone++;
    end
    check("abort no Done", 64'(ndone), 64'd0);

    // MTHI / MTLO while idle.
    A = 32'h0000_1234; WrHI = 1'b1;
    @(posedge clk); #1;
    WrHI = 1'b0;
    check("WrHI HI", {32'd0, HI}, 64'h1234);
    check("WrHI LO untouched", {32'd0, LO}, 64'd0);
    A = 32'h0000_ABCD; WrLO = 1'b1;
    @(posedge clk); #1;
    WrLO = 1'b0;
    check("WrLO LO", {32'd0, LO}, 64'hABCD);
    A = 32'h0000_0055; WrHI = 1'b1; WrLO = 1'b1;
    @(posedge clk); #1;
    WrHI = 1'b0; WrLO = 1'b0;
    check("WrHI+WrLO HI", {32'd0, HI}, 64'h55);
    check("WrHI+WrLO LO", {32'd0, LO}, 64'h55);

    // Start together with WrHI: the write is dropped.
    WrHI = 1'b1;
    start_op(2'b10, 32'h77, 32'd2, model(2'b10, 32'h77, 32'd2));
    WrHI = 1'b0;
    check("start-wins HI held", {32'd0, HI}, 64'h55);
    wait_done("start-wins", 0, lat, bc);
    check("start-wins latency", 64'(lat), 64'd33);

    // WrLO while busy is ignored.
    start_op(2'b00, 32'd6, 32'd7, model(2'b00, 32'd6, 32'd7));
    repeat (4) @(posedge clk);
    #1;
    A = 32'h0000_DEAD; WrLO = 1'b1;
    @(posedge clk); #1;
    WrLO = 1'b0;
    check("busy WrLO ignored", {32'd0, LO}, 64'h3B);
    wait_done("busy-WrLO", 5, lat, bc);
    check("busy-WrLO latency", 64'(lat), 64'd33);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
